config_loader: RTL and testbench
================================

# config_loader

Configuration loader for the FPGA fabric. It accepts a byte-wide bitstream over a valid/ready stream and serializes it onto the configuration chain formed by the logic clusters' `prog_in`/`prog_out` links, generating `prog_clk` and `prog_en` itself. It has an optional verify pass. In that pass it re-shifts the same bitstream and compares the bits emerging from the chain tail against the bits being shifted in.

## Interface

Parameters:
- `CHAIN_LEN`, default 128: total configuration bits in the chain; must be ≥ 1.
- `CLK_DIV`, default 2: clk cycles per `prog_clk` phase, low and high; must be ≥ 1.

Ports:
- `clk`, in, 1: system clock. All logic is on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle request to begin a pass; sampled only in IDLE.
- `verify`, in, 1: sampled with `start`. 0 = load pass, 1 = load-and-verify pass.
- `in_data`, in, 8: bitstream byte; shifted LSB first.
- `in_valid`, in, 1: `in_data` is valid.
- `in_ready`, out, 1: loader accepts a byte this cycle.
- `prog_in`, out, 1: serial configuration data to the chain head.
- `prog_clk`, out, 1: configuration shift clock; the chain shifts on its rising edge.
- `prog_en`, out, 1: configuration enable to the chain.
- `prog_out`, in, 1: serial data from the chain tail.
- `busy`, out, 1: a pass is in progress.
- `done`, out, 1: one-cycle pulse when a pass completes.
- `mismatch`, out, 1: sticky verify-failure flag; cleared by an accepted `start`.

## Operation

- States:
  - IDLE: `busy` = 0.
  - FETCH: `in_ready` = 1; waits for a byte.
  - SHIFT_LO: `prog_clk` = 0.
  - SHIFT_HI: `prog_clk` = 1.
  - FINISH.
- Registers:
  - byte register.
  - 3-bit bit index.
  - bit counter, width clog2(CHAIN_LEN+1).
  - phase counter, width clog2(CLK_DIV+1).
  - verify-mode flag.
- IDLE → FETCH on `start`. The transition clears the bit counter and `mismatch`, latches `verify`, and sets `busy` = 1 and `prog_en` = 1. `start` is ignored in all other states.
- FETCH → SHIFT_LO on `in_valid && in_ready`. The byte is registered and the bit index reset to 0. Without `in_valid`, the loader stays in FETCH indefinitely, with `prog_clk` = 0 and `prog_in` held.
- SHIFT_LO:
  - `prog_in` = byte[bit index] for all CLK_DIV cycles.
  - On the last cycle, if in verify mode and `prog_out` != `prog_in`, `mismatch` is set.
  - Then → SHIFT_HI.
- SHIFT_HI: `prog_clk` = 1 for CLK_DIV cycles. On the last cycle the bit counter increments, then:
  - if the counter reaches CHAIN_LEN → FINISH;
  - else if the bit index is 7 → FETCH;
  - else the bit index increments → SHIFT_LO.
- FINISH (one cycle): `prog_clk` = 0, `prog_en` = 0, `done` = 1, `busy` = 0, then → IDLE. Unused upper bits of the final byte are discarded.
- Verify rationale: after a full load, `prog_out` before the k-th rising edge of a second identical load equals bit k of the previous load. An identical bitstream therefore yields `mismatch` = 0 and leaves the chain holding the same configuration.
- Reset values: `in_ready`, `prog_in`, `prog_clk`, `prog_en`, `busy`, `done` and `mismatch` are all 0; the state is IDLE.

## Timing

- Cycle numbering, with `start` sampled at cycle 0:
  - cycle 1: FETCH, `in_ready` = 1, `prog_en` = 1.
  - byte accepted at cycle t: `prog_in` carries bit 0 during t+1 … t+CLK_DIV, and `prog_clk` is high during t+CLK_DIV+1 … t+2·CLK_DIV.
  - next bit of the same byte appears at t+2·CLK_DIV+1.
- Minimum cycles per full byte: 16·CLK_DIV + 1, counting from acceptance to the next `in_ready`.
- `prog_in` changes only when `prog_clk` = 0 and stays stable for a full high phase.
- `in_ready` is asserted only in FETCH, never combinationally from `in_valid`.
- Reset mid-pass: all outputs return to their reset values immediately (asynchronous). Chain contents are then undefined, and no `done` pulse is produced.
- If the final bit is the last bit of a byte, the loader goes to FINISH, not FETCH, and no extra byte is requested.

## Test plan

Bench parameters: CHAIN_LEN=20, CLK_DIV=1. The chain is modelled as a 20-bit shift register clocked by `prog_clk`, gated by `prog_en`.

1. Load with bytes 0xA5, 0x3C, 0x0F and `in_valid` always high → exactly 20 `prog_clk` rising edges and exactly 3 bytes accepted. The model's first-in bit is 1 (0xA5 bit 0), `done` pulses once, and `prog_en` falls with `done`.
2. Verify pass with the same three bytes after test 1 → `mismatch` = 0 at `done`. Verify again with the second byte 0x3D → `mismatch` = 1, the chain holds the new data, and `mismatch` clears on the next `start`.
3. Hold `in_valid` low for 10 cycles before the second byte → `prog_clk` stays 0 and `prog_in` stays constant throughout the stall; the final chain contents are unchanged versus test 1.
4. Assert `start` during a pass, and again 3 cycles after `done` → the first is ignored (the bit count stays 20). The second starts a new pass with `in_ready` = 1 exactly one cycle later.
5. Pulse `rst_n` low mid-byte → all outputs go to 0 asynchronously. A subsequent full load completes normally with 20 edges.
6. Re-run test 1 with CLK_DIV=3 → each `prog_clk` phase lasts 3 cycles, with 16·3+1 cycles between the first and second byte acceptances.

Source files
------------

// File: rtl/config_loader.sv
// Configuration chain loader: serializes a byte stream LSB-first onto the
// prog_in/prog_clk chain, with an optional verify pass comparing prog_out.
`timescale 1ns/1ps
module config_loader #(
  parameter int unsigned CHAIN_LEN = 128,
  parameter int unsigned CLK_DIV   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       verify,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       prog_in,
  output logic       prog_clk,
  output logic       prog_en,
  input  logic       prog_out,
  output logic       busy,
  output logic       done,
  output logic       mismatch
);

  localparam int unsigned CW = $clog2(CHAIN_LEN + 1);
  localparam int unsigned PW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CHAIN_LEN - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_FINISH
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [7:0]      r_byte;
  logic [2:0]      r_idx;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   r_phase;
  logic            r_verify;
  logic            r_mismatch;
  logic            r_prog_in;
  logic            w_phase_last;
  logic            w_cnt_last;

  assign w_phase_last = (r_phase == PH_LAST);
  assign w_cnt_last   = (r_cnt == CNT_LAST);
  assign prog_in      = r_prog_in;
  assign mismatch     = r_mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    prog_clk = 1'b0;
    prog_en  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_FETCH;
      end
      S_FETCH: begin
        in_ready = 1'b1;
        prog_en  = 1'b1;
        busy     = 1'b1;
        if (in_valid) w_next = S_SHIFT_LO;
      end
      S_SHIFT_LO: begin
        prog_en = 1'b1;
        busy    = 1'b1;
        if (w_phase_last) w_next = S_SHIFT_HI;
      end
      S_SHIFT_HI: begin
        prog_clk = 1'b1;
        prog_en  = 1'b1;
        busy     = 1'b1;
        if (w_phase_last) begin
          if (w_cnt_last)         w_next = S_FINISH;
          else if (r_idx == 3'd7) w_next = S_FETCH;
          else                    w_next = S_SHIFT_LO;
        end
      end
      S_FINISH: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // prog_in is loaded only on entry to SHIFT_LO, so it holds through the
  // high phase and any FETCH stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte     <= '0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_phase    <= '0;
      r_verify   <= 1'b0;
      r_mismatch <= 1'b0;
      r_prog_in  <= 1'b0;
    end else begin
      if (r_state != w_next) r_phase <= '0;
      else if (r_state == S_SHIFT_LO || r_state == S_SHIFT_HI) r_phase <= r_phase + PW'(1);

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt      <= '0;
            r_mismatch <= 1'b0;
            r_verify   <= verify;
          end
        end
        S_FETCH: begin
          if (in_valid) begin
            r_byte    <= in_data;
            r_idx     <= '0;
            r_prog_in <= in_data[0];
          end
        end
        S_SHIFT_LO: begin
          if (w_phase_last && r_verify && (prog_out != r_prog_in)) r_mismatch <= 1'b1;
        end
        S_SHIFT_HI: begin
          if (w_phase_last) begin
            r_cnt <= r_cnt + CW'(1);
            if (!w_cnt_last && r_idx != 3'd7) begin
              r_idx     <= r_idx + 3'd1;
              r_prog_in <= r_byte[r_idx + 3'd1];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader: two instances (CLK_DIV 1 and 3) driving modelled
// 20-bit configuration chains, checked against stream-level expectations.
`timescale 1ns/1ps
module tb_config_loader;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] start    = '0;
  logic [1:0] verify   = '0;
  logic [1:0] in_valid = '0;
  logic [7:0] in_data [2];
  logic [1:0] in_ready, prog_in, prog_clk, prog_en, prog_out, busy, done, mismatch;
  logic [19:0] chain0 = '0;
  logic [19:0] chain1 = '0;
  logic [1:0]  pclk_q = '0;

  int npass = 0, ntot = 0, nfail = 0;
  int cyc = 0;
  int acc[2]    = '{0, 0};
  int edges[2]  = '{0, 0};
  int dones[2]  = '{0, 0};
  int t_prev[2] = '{0, 0};
  int t_last[2] = '{0, 0};
  int hi_run[2] = '{0, 0};
  int lo_run[2] = '{0, 0};
  int hi_bad[2] = '{0, 0};
  int lo_bad[2] = '{0, 0};

  always #5 clk = ~clk;

  config_loader #(.CHAIN_LEN(20), .CLK_DIV(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .verify(verify[0]),
    .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .prog_in(prog_in[0]), .prog_clk(prog_clk[0]), .prog_en(prog_en[0]),
    .prog_out(prog_out[0]), .busy(busy[0]), .done(done[0]), .mismatch(mismatch[0])
  );

  config_loader #(.CHAIN_LEN(20), .CLK_DIV(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .verify(verify[1]),
    .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .prog_in(prog_in[1]), .prog_clk(prog_clk[1]), .prog_en(prog_en[1]),
    .prog_out(prog_out[1]), .busy(busy[1]), .done(done[1]), .mismatch(mismatch[1])
  );

  // Chain model: a plain shift register clocked by prog_clk, gated by prog_en.
  assign prog_out[0] = chain0[19];
  assign prog_out[1] = chain1[19];
  always @(posedge prog_clk[0]) if (prog_en[0]) chain0 <= {chain0[18:0], prog_in[0]};
  always @(posedge prog_clk[1]) if (prog_en[1]) chain1 <= {chain1[18:0], prog_in[1]};

  function automatic int cdiv(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [19:0] get_chain(input int d);
    return (d == 0) ? chain0 : chain1;
  endfunction

  // Activity monitor, sampled on the inactive clock edge.
  always @(negedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (in_valid[d] && in_ready[d]) begin
        acc[d]++;
        t_prev[d] = t_last[d];
        t_last[d] = cyc;
      end
      if (done[d]) dones[d]++;
      if (prog_clk[d] && !pclk_q[d] && prog_en[d]) edges[d]++;
      pclk_q[d] = prog_clk[d];
      if (prog_clk[d]) begin
        hi_run[d]++;
        if (lo_run[d] != 0 && lo_run[d] != cdiv(d)) lo_bad[d]++;
        lo_run[d] = 0;
      end else begin
        if (hi_run[d] != 0 && hi_run[d] != cdiv(d)) hi_bad[d]++;
        hi_run[d] = 0;
        if (busy[d] && !in_ready[d]) lo_run[d]++;
        else lo_run[d] = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete pass on instance d; expectations derive from the bit stream.
  task automatic run_pass(input int d, input bit vfy, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input int stall_at, input bit mid_start);
    logic [7:0]  bytes [3];
    logic [19:0] s, old, exp_chain, ch;
    logic        held;
    bit          exp_mm;
    int          a0, e0, n0, hb0, lb0, k;
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
    ch = get_chain(d);
    for (int i = 0; i < 20; i++) begin
      s[i]              = bytes[i / 8][i % 8];
      old[i]            = ch[19 - i];
      exp_chain[19 - i] = s[i];
    end
    exp_mm = vfy && (old != s);
    a0 = acc[d]; e0 = edges[d]; n0 = dones[d]; hb0 = hi_bad[d]; lb0 = lo_bad[d];

    check("idle_ready", {31'd0, in_ready[d]}, 32'd0);
    start[d] = 1'b1; verify[d] = vfy; in_data[d] = b0; in_valid[d] = (stall_at != 0);
    step();
    start[d] = 1'b0; verify[d] = 1'($urandom_range(0, 1));
    check("fetch_ready", {31'd0, in_ready[d]}, 32'd1);
    check("fetch_en",    {31'd0, prog_en[d]},  32'd1);
    check("fetch_busy",  {31'd0, busy[d]},     32'd1);
    check("mm_cleared",  {31'd0, mismatch[d]}, 32'd0);

    for (int j = 0; j < 3; j++) begin
      if (j == stall_at) begin
        in_valid[d] = 1'b0;
        k = 0;
        while (!in_ready[d] && k < 400) begin step(); k++; end
        check("stall_reach", {31'd0, in_ready[d]}, 32'd1);
        held = prog_in[d];
        repeat (10) begin
          check("stall_clk", {31'd0, prog_clk[d]}, 32'd0);
          check("stall_in",  {31'd0, prog_in[d]},  {31'd0, held});
          step();
        end
      end
      in_data[d] = bytes[j]; in_valid[d] = 1'b1;
      k = 0;
      while (acc[d] != a0 + j + 1 && k < 400) begin step(); k++; end
      check("accept", acc[d] - a0, j + 1);
      if (j == 1 && stall_at != 1) check("byte_gap", t_last[d] - t_prev[d], 16 * cdiv(d) + 1);
      if (j == 0 && mid_start) begin
        start[d] = 1'b1; verify[d] = !vfy;
        step();
        start[d] = 1'b0;
      end
    end
    in_data[d] = 8'($urandom);

    k = 0;
    while (!done[d] && k < 600) begin step(); k++; end
    check("done",       {31'd0, done[d]},     32'd1);
    check("done_en",    {31'd0, prog_en[d]},  32'd0);
    check("done_busy",  {31'd0, busy[d]},     32'd0);
    check("done_clk",   {31'd0, prog_clk[d]}, 32'd0);
    check("edges",      edges[d] - e0, 20);
    check("mismatch",   {31'd0, mismatch[d]}, {31'd0, exp_mm});
    check("chain",      {12'd0, get_chain(d)}, {12'd0, exp_chain});
    repeat (2) begin
      step();
      check("done_once",  {31'd0, done[d]},     32'd0);
      check("idle_busy",  {31'd0, busy[d]},     32'd0);
      check("idle_ready", {31'd0, in_ready[d]}, 32'd0);
    end
    check("done_count", dones[d] - n0, 1);
    check("bytes",      acc[d] - a0, 3);
    check("edges_post", edges[d] - e0, 20);
    check("hi_phase",   hi_bad[d] - hb0, 0);
    check("lo_phase",   lo_bad[d] - lb0, 0);
    check("mm_sticky",  {31'd0, mismatch[d]}, {31'd0, exp_mm});
    in_valid[d] = 1'b0;
  endtask

  initial begin
    logic [19:0] t1;
    logic [7:0]  p0, p1, p2;
    bit          vr;
    in_data[0] = '0; in_data[1] = '0;
    #2;
    check("reset_outs", {18'd0, in_ready, prog_in, prog_clk, prog_en, busy, done, mismatch}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Plain load, in_valid held high throughout.
    run_pass(0, 1'b0, 8'hA5, 8'h3C, 8'h0F, -1, 1'b0);
    check("first_bit", {31'd0, chain0[19]}, 32'd1);
    t1 = chain0;

    // Verify with identical stream, then with a corrupted second byte.
    run_pass(0, 1'b1, 8'hA5, 8'h3C, 8'h0F, -1, 1'b0);
    run_pass(0, 1'b1, 8'hA5, 8'h3D, 8'h0F, -1, 1'b0);

    // Stall before the second byte.
    run_pass(0, 1'b0, 8'hA5, 8'h3C, 8'h0F, 1, 1'b0);
    check("stall_chain", {12'd0, chain0}, {12'd0, t1});

    // start during a pass is ignored; restart three cycles after done.
    run_pass(0, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom), -1, 1'b1);
    step();
    run_pass(0, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom), -1, 1'b0);

    // Asynchronous reset in the middle of a byte.
    in_data[0] = 8'h5A; in_valid[0] = 1'b1; start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    repeat (5) step();
    check("pre_rst_busy", {31'd0, busy[0]}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async", {25'd0, in_ready[0], prog_in[0], prog_clk[0], prog_en[0], busy[0], done[0], mismatch[0]}, 32'd0);
    step();
    rst_n = 1'b1; in_valid[0] = 1'b0;
    step();
    p0 = 8'($urandom); p1 = 8'($urandom); p2 = 8'($urandom);
    run_pass(0, 1'b0, p0, p1, p2, -1, 1'b0);

    // Randomized passes: random bytes or a repeat, random verify and stall.
    for (int n = 0; n < 6; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        p0 = 8'($urandom); p1 = 8'($urandom); p2 = 8'($urandom);
      end
      vr = 1'($urandom_range(0, 1));
      run_pass(0, vr, p0, p1, p2, int'($urandom_range(0, 3)) - 1, 1'($urandom_range(0, 1)));
    end

    // Slower prog_clk instance.
    run_pass(1, 1'b0, 8'hA5, 8'h3C, 8'h0F, -1, 1'b0);
    check("first_bit_cd3", {31'd0, chain1[19]}, 32'd1);
    run_pass(1, 1'b1, 8'hA5, 8'h3C, 8'h0F, -1, 1'b0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
